sync_fifo: RTL and testbench

- Single-clock FIFO; the next generation of the team's dual-clock FIFO for paths where producer and consumer share one clock.
- No pointer synchronisers. Binary pointers with an explicit fill-level counter.
- Adds a level output, synchronous flush, exact threshold flags and a selectable read mode (first-word fall-through or registered).
- Used as an elastic buffer between pipeline stages inside one clock domain.

---
 rtl/sync_fifo_pkg.sv | 26 ++
 rtl/sync_fifo_if.sv | 40 ++++
 rtl/sync_fifo_ram.sv | 47 ++++
 rtl/sync_fifo.sv | 116 +++++++++++
 tb/tb_sync_fifo.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and parameter checks for sync_fifo
package sync_fifo_pkg;

    localparam string FT_TRUE  = "TRUE";
    localparam string FT_FALSE = "FALSE";

    function automatic int calc_depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic bit params_ok(
        input int dsize,
        input int asize,
        input int awfullsize,
        input int aremptysize,
        input bit ft_valid
    );
        int depth;
        depth = calc_depth(asize);
        return (dsize >= 1) && (asize >= 1) &&
               (awfullsize >= 1) && (awfullsize < depth) &&
               (aremptysize >= 1) && (aremptysize < depth) &&
               ft_valid;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - sync_fifo producer/consumer bundle; SYNC_FIFO_ERR_EN adds error signals
interface sync_fifo_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             flush;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             awfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             arempty;
    logic [ASIZE:0]   level;
`ifdef SYNC_FIFO_ERR_EN
    logic             err_clr;
    logic             overflow;
    logic             underflow;
`endif

    modport master (
`ifdef SYNC_FIFO_ERR_EN
        output err_clr,
        input  overflow, underflow,
`endif
        output flush, winc, wdata, rinc,
        input  wfull, awfull, rdata, rempty, arempty, level
    );

    modport slave (
`ifdef SYNC_FIFO_ERR_EN
        input  err_clr,
        output overflow, underflow,
`endif
        input  flush, winc, wdata, rinc,
        output wfull, awfull, rdata, rempty, arempty, level
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port storage with fall-through or registered read
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter string FALLTHROUGH = FT_TRUE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH   = calc_depth(ASIZE);
    localparam bit FT_MODE = (FALLTHROUGH == FT_TRUE);

    logic [DSIZE-1:0] mem [DEPTH];

    // Contents are deliberately left unreset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (FT_MODE) begin : g_fallthrough
            logic unused_rd;
            assign rdata     = mem[raddr];
            assign unused_rd = &{1'b0, re, rst_n};
        end else begin : g_registered
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level, flush and threshold flags; SYNC_FIFO_ERR_EN adds sticky error flags
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter int    AWFULLSIZE  = 1,
    parameter int    AREMPTYSIZE = 1,
    parameter string FALLTHROUGH = FT_TRUE
) (
    input  logic     clk,
    input  logic     rst_n,
    sync_fifo_if.slave bus
);

    localparam int DEPTH    = calc_depth(ASIZE);
    localparam bit FT_VALID = (FALLTHROUGH == FT_TRUE) || (FALLTHROUGH == FT_FALSE);

    localparam logic [ASIZE:0] LVL_FULL = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] LVL_AF   = (ASIZE+1)'(DEPTH - AWFULLSIZE);
    localparam logic [ASIZE:0] LVL_AE   = (ASIZE+1)'(AREMPTYSIZE);

    generate
        if (!params_ok(DSIZE, ASIZE, AWFULLSIZE, AREMPTYSIZE, FT_VALID)) begin : g_param_err
            $error("sync_fifo: illegal parameter combination");
        end
    endgenerate

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic [ASIZE:0] level;
    logic           wfull_w;
    logic           rempty_w;
    logic           wr_ok;
    logic           rd_ok;

    // Flags come from the level register only, so winc/rinc never reach them combinationally.
    assign wfull_w  = (level == LVL_FULL);
    assign rempty_w = (level == '0);

    assign bus.wfull   = wfull_w;
    assign bus.rempty  = rempty_w;
    assign bus.awfull  = (level >= LVL_AF);
    assign bus.arempty = (level <= LVL_AE);
    assign bus.level   = level;

    assign wr_ok = bus.winc & ~wfull_w  & ~bus.flush;
    assign rd_ok = bus.rinc & ~rempty_w & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (bus.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                level <= level + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                level <= level - 1'b1;
            end
        end
    end

    sync_fifo_ram #(
        .DSIZE       (DSIZE),
        .ASIZE       (ASIZE),
        .FALLTHROUGH (FALLTHROUGH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (bus.wdata),
        .re    (rd_ok),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (bus.rdata)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // A new error event in the same cycle as err_clr keeps the flag set; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.winc && wfull_w) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (bus.rinc && rempty_w) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed bench driving a fall-through and a registered sync_fifo in lockstep
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
`ifdef SYNC_FIFO_ERR_EN
    logic       err_clr;
`endif

    int checks;
    int errors;

    sync_fifo_if #(.DSIZE(8), .ASIZE(4)) if_ft ();
    sync_fifo_if #(.DSIZE(8), .ASIZE(4)) if_rg ();

    assign if_ft.flush = flush;
    assign if_ft.winc  = winc;
    assign if_ft.wdata = wdata;
    assign if_ft.rinc  = rinc;
    assign if_rg.flush = flush;
    assign if_rg.winc  = winc;
    assign if_rg.wdata = wdata;
    assign if_rg.rinc  = rinc;
`ifdef SYNC_FIFO_ERR_EN
    assign if_ft.err_clr = err_clr;
    assign if_rg.err_clr = err_clr;
`endif

    sync_fifo #(
        .DSIZE(8), .ASIZE(4), .AWFULLSIZE(2), .AREMPTYSIZE(1), .FALLTHROUGH("TRUE")
    ) dut_ft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_ft)
    );

    sync_fifo #(
        .DSIZE(8), .ASIZE(4), .AWFULLSIZE(2), .AREMPTYSIZE(1), .FALLTHROUGH("FALSE")
    ) dut_rg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (if_ft.level !== 5'd0) begin errors++; $display("FAIL reset_level_ft got %0d exp 0", if_ft.level); end
        checks++; if (if_rg.level !== 5'd0) begin errors++; $display("FAIL reset_level_rg got %0d exp 0", if_rg.level); end
        checks++; if (if_ft.rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b exp 1", if_ft.rempty); end
        checks++; if (if_ft.arempty !== 1'b1) begin errors++; $display("FAIL reset_arempty got %b exp 1", if_ft.arempty); end
        checks++; if (if_ft.wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b exp 0", if_ft.wfull); end
        checks++; if (if_ft.awfull !== 1'b0) begin errors++; $display("FAIL reset_awfull got %b exp 0", if_ft.awfull); end
        checks++; if (if_rg.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata_rg got %h exp 00", if_rg.rdata); end
`ifdef SYNC_FIFO_ERR_EN
        checks++; if (if_ft.overflow !== 1'b0 || if_ft.underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", if_ft.overflow, if_ft.underflow); end
`endif
    endtask

    task automatic test_fill();
        int lvl;
        winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(i);
            step();
            lvl = i + 1;
            checks++; if (if_ft.level !== 5'(lvl)) begin errors++; $display("FAIL fill_level got %0d exp %0d", if_ft.level, lvl); end
            checks++; if (if_ft.awfull !== (lvl >= 14)) begin errors++; $display("FAIL fill_awfull at %0d got %b exp %b", lvl, if_ft.awfull, (lvl >= 14)); end
            checks++; if (if_ft.wfull !== (lvl == 16)) begin errors++; $display("FAIL fill_wfull at %0d got %b exp %b", lvl, if_ft.wfull, (lvl == 16)); end
            checks++; if (if_ft.arempty !== (lvl <= 1)) begin errors++; $display("FAIL fill_arempty at %0d got %b exp %b", lvl, if_ft.arempty, (lvl <= 1)); end
            checks++; if (if_rg.level !== 5'(lvl)) begin errors++; $display("FAIL fill_level_rg got %0d exp %0d", if_rg.level, lvl); end
        end
        wdata = 8'hEE;
        step();
        winc = 1'b0;
        checks++; if (if_ft.level !== 5'd16) begin errors++; $display("FAIL overflow_level got %0d exp 16", if_ft.level); end
        checks++; if (if_ft.wfull !== 1'b1) begin errors++; $display("FAIL overflow_wfull got %b exp 1", if_ft.wfull); end
`ifdef SYNC_FIFO_ERR_EN
        checks++; if (if_ft.overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag_ft got %b exp 1", if_ft.overflow); end
        checks++; if (if_rg.overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag_rg got %b exp 1", if_rg.overflow); end
`endif
    endtask

    task automatic test_drain();
        rinc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (if_ft.rdata !== 8'(i)) begin errors++; $display("FAIL drain_ft word %0d got %h exp %h", i, if_ft.rdata, 8'(i)); end
            step();
            checks++; if (if_rg.rdata !== 8'(i)) begin errors++; $display("FAIL drain_rg word %0d got %h exp %h", i, if_rg.rdata, 8'(i)); end
            checks++; if (if_ft.level !== 5'(15 - i)) begin errors++; $display("FAIL drain_level got %0d exp %0d", if_ft.level, 15 - i); end
        end
        checks++; if (if_ft.rempty !== 1'b1 || if_rg.rempty !== 1'b1) begin errors++; $display("FAIL drain_rempty got %b%b exp 11", if_ft.rempty, if_rg.rempty); end
        step();
        rinc = 1'b0;
        checks++; if (if_ft.level !== 5'd0) begin errors++; $display("FAIL underflow_level got %0d exp 0", if_ft.level); end
        checks++; if (if_rg.rdata !== 8'h0F) begin errors++; $display("FAIL underflow_rdata_hold got %h exp 0f", if_rg.rdata); end
`ifdef SYNC_FIFO_ERR_EN
        checks++; if (if_ft.underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag got %b exp 1", if_ft.underflow); end
        rinc = 1'b1;
        err_clr = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (if_ft.underflow !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", if_ft.underflow); end
        checks++; if (if_ft.overflow !== 1'b0) begin errors++; $display("FAIL err_clr_overflow got %b exp 0", if_ft.overflow); end
        step();
        err_clr = 1'b0;
        checks++; if (if_ft.underflow !== 1'b0) begin errors++; $display("FAIL err_clr_underflow got %b exp 0", if_ft.underflow); end
`endif
    endtask

    task automatic test_boundary();
        winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(8'h30 + i);
            step();
        end
        checks++; if (if_ft.level !== 5'd16) begin errors++; $display("FAIL bnd_full_level got %0d exp 16", if_ft.level); end
        wdata = 8'h77;
        rinc  = 1'b1;
        checks++; if (if_ft.rdata !== 8'h30) begin errors++; $display("FAIL bnd_full_head got %h exp 30", if_ft.rdata); end
        step();
        winc = 1'b0;
        checks++; if (if_ft.level !== 5'd15) begin errors++; $display("FAIL bnd_full_level_after got %0d exp 15", if_ft.level); end
        checks++; if (if_ft.wfull !== 1'b0) begin errors++; $display("FAIL bnd_full_wfull got %b exp 0", if_ft.wfull); end
        checks++; if (if_rg.rdata !== 8'h30) begin errors++; $display("FAIL bnd_full_pop_rg got %h exp 30", if_rg.rdata); end
        checks++; if (if_ft.rdata !== 8'h31) begin errors++; $display("FAIL bnd_full_next_ft got %h exp 31", if_ft.rdata); end
        for (int i = 0; i < 15; i++) begin
            step();
        end
        checks++; if (if_ft.rempty !== 1'b1) begin errors++; $display("FAIL bnd_drain_rempty got %b exp 1", if_ft.rempty); end
        checks++; if (if_rg.rdata !== 8'h3F) begin errors++; $display("FAIL bnd_drain_last got %h exp 3f", if_rg.rdata); end
        winc  = 1'b1;
        wdata = 8'h5A;
        step();
        winc = 1'b0;
        checks++; if (if_ft.level !== 5'd1) begin errors++; $display("FAIL bnd_empty_level got %0d exp 1", if_ft.level); end
        checks++; if (if_ft.rempty !== 1'b0) begin errors++; $display("FAIL bnd_empty_rempty got %b exp 0", if_ft.rempty); end
        checks++; if (if_ft.rdata !== 8'h5A) begin errors++; $display("FAIL bnd_empty_word_ft got %h exp 5a", if_ft.rdata); end
        checks++; if (if_rg.rdata !== 8'h3F) begin errors++; $display("FAIL bnd_empty_hold_rg got %h exp 3f", if_rg.rdata); end
        step();
        rinc = 1'b0;
        checks++; if (if_rg.rdata !== 8'h5A) begin errors++; $display("FAIL bnd_empty_word_rg got %h exp 5a", if_rg.rdata); end
        checks++; if (if_rg.level !== 5'd0) begin errors++; $display("FAIL bnd_empty_final got %0d exp 0", if_rg.level); end
    endtask

    task automatic test_flush();
        winc = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wdata = 8'(8'h40 + i);
            step();
        end
        checks++; if (if_ft.level !== 5'd7) begin errors++; $display("FAIL flush_pre_level got %0d exp 7", if_ft.level); end
        flush = 1'b1;
        wdata = 8'hFF;
        step();
        flush = 1'b0;
        checks++; if (if_ft.level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", if_ft.level); end
        checks++; if (if_ft.rempty !== 1'b1 || if_ft.arempty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b%b exp 11", if_ft.rempty, if_ft.arempty); end
        checks++; if (if_rg.rdata !== 8'h5A) begin errors++; $display("FAIL flush_rdata_hold got %h exp 5a", if_rg.rdata); end
        wdata = 8'hA5;
        step();
        winc = 1'b0;
        checks++; if (if_ft.level !== 5'd1) begin errors++; $display("FAIL flush_post_level got %0d exp 1", if_ft.level); end
        checks++; if (if_ft.rdata !== 8'hA5) begin errors++; $display("FAIL flush_post_ft got %h exp a5", if_ft.rdata); end
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (if_rg.rdata !== 8'hA5) begin errors++; $display("FAIL flush_post_rg got %h exp a5", if_rg.rdata); end
    endtask

    task automatic test_async_reset();
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'(8'h60 + i);
            step();
        end
        winc = 1'b0;
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (if_rg.rdata !== 8'h60) begin errors++; $display("FAIL areset_pre_rdata got %h exp 60", if_rg.rdata); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if_ft.level !== 5'd0 || if_rg.level !== 5'd0) begin errors++; $display("FAIL areset_level got %0d/%0d exp 0", if_ft.level, if_rg.level); end
        checks++; if (if_ft.rempty !== 1'b1) begin errors++; $display("FAIL areset_rempty got %b exp 1", if_ft.rempty); end
        checks++; if (if_rg.rdata !== 8'h00) begin errors++; $display("FAIL areset_rdata got %h exp 00", if_rg.rdata); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        winc    = 1'b0;
        wdata   = 8'h00;
        rinc    = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        #12;
        test_reset();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_fill();
        test_drain();
        test_boundary();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
